// File: rtl/physics_pkg.sv
// Shared record layouts and scheduler state encoding for the collision pipeline.
package physics_pkg;

  localparam int unsigned POS_W     = 22;
  localparam int unsigned HALF_W    = 22;
  localparam int unsigned AXIS_W    = 16;
  localparam int unsigned NORMAL_W  = 16;
  localparam int unsigned LOC_W     = 22;
  localparam int unsigned PEN_W     = 24;
  localparam int unsigned OBB_PAD_W = 8;

  // Oriented bounding box: centre, half extents and the two unit axes.
  // The top byte pads the record to a 160-bit RAM word.
  typedef struct packed {
    logic [OBB_PAD_W-1:0] rsvd;
    logic [POS_W-1:0]     pos_x;
    logic [POS_W-1:0]     pos_y;
    logic [HALF_W-1:0]    half_width;
    logic [HALF_W-1:0]    half_height;
    logic [AXIS_W-1:0]    u_x;
    logic [AXIS_W-1:0]    u_y;
    logic [AXIS_W-1:0]    v_x;
    logic [AXIS_W-1:0]    v_y;
  } obb_t;

  // Contact produced by the detector for one colliding pair.
  typedef struct packed {
    logic [NORMAL_W-1:0] normal_x;
    logic [NORMAL_W-1:0] normal_y;
    logic [LOC_W-1:0]    loc_x;
    logic [LOC_W-1:0]    loc_y;
    logic [PEN_W-1:0]    penetration;
  } contact_t;

  localparam int unsigned OBB_BITS     = $bits(obb_t);
  localparam int unsigned CONTACT_BITS = $bits(contact_t);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_CAP_A,
    ST_RD_B,
    ST_CAP_B,
    ST_EVAL,
    ST_EMIT,
    ST_DONE
  } sched_state_t;

endpackage

// File: rtl/pair_iterator.sv
// Walks the (i,j) body pairs in lexicographic order; one extra bit keeps end checks from wrapping.
module pair_iterator #(
  parameter int unsigned NUM_BODIES = 8,
  parameter int unsigned CNT_W      = $clog2(NUM_BODIES) + 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             init,
  input  logic             advance,
  output logic [CNT_W-1:0] i,
  output logic [CNT_W-1:0] j,
  output logic [CNT_W-1:0] i_nxt_c,
  output logic [CNT_W-1:0] j_nxt_c,
  output logic             i_last_c,
  output logic             j_last_c
);

  // End-of-row / end-of-pass flags and the index values after this cycle
  always_comb begin
    j_last_c = (j >= CNT_W'(NUM_BODIES - 1));
    i_last_c = (i >= CNT_W'(NUM_BODIES - 2));
    i_nxt_c  = i;
    j_nxt_c  = j;
    if (init) begin
      i_nxt_c = '0;
      j_nxt_c = CNT_W'(1);
    end else if (advance) begin
      if (!j_last_c) begin
        j_nxt_c = j + CNT_W'(1);
      end else if (!i_last_c) begin
        i_nxt_c = i + CNT_W'(1);
        j_nxt_c = i + CNT_W'(2);
      end
    end
  end

  // Index registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      i <= '0;
      j <= '0;
    end else begin
      i <= i_nxt_c;
      j <= j_nxt_c;
    end
  end

endmodule

// File: rtl/collision_pair_scheduler.sv
// Sequences every body pair from RAM into the OBB detector and streams out real contacts.
module collision_pair_scheduler
  import physics_pkg::*;
#(
  parameter int unsigned NUM_BODIES = 8,
  parameter int unsigned IDX_W      = $clog2(NUM_BODIES),
  parameter int unsigned OBB_W      = OBB_BITS,
  parameter int unsigned CONTACT_W  = CONTACT_BITS
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  start,
  input  logic [NUM_BODIES-1:0] active_mask,
  output logic                  busy,
  output logic                  done,
  output logic                  body_rd_en,
  output logic [IDX_W-1:0]      body_rd_addr,
  input  logic [OBB_W-1:0]      body_rd_data,
  output logic [OBB_W-1:0]      obb1_o,
  output logic [OBB_W-1:0]      obb2_o,
  input  logic                  det_is_collision,
  input  logic [CONTACT_W-1:0]  det_contact,
  output logic                  contact_valid,
  input  logic                  contact_ready,
  output logic [CONTACT_W-1:0]  contact_data,
  output logic [IDX_W-1:0]      contact_idx_a,
  output logic [IDX_W-1:0]      contact_idx_b,
  output logic [15:0]           contact_count
);

  localparam int unsigned CNT_W = IDX_W + 1;

  if (NUM_BODIES < 2) begin : g_chk_bodies
    $error("collision_pair_scheduler: NUM_BODIES must be at least 2");
  end
  if (OBB_W != OBB_BITS || CONTACT_W != CONTACT_BITS) begin : g_chk_widths
    $error("collision_pair_scheduler: OBB_W/CONTACT_W must match physics_pkg records");
  end

  sched_state_t          state;
  sched_state_t          state_nxt;
  sched_state_t          adv_state;
  logic [NUM_BODIES-1:0] mask_q;
  contact_t              contact_q;
  logic [CNT_W-1:0]      i;
  logic [CNT_W-1:0]      j;
  logic [CNT_W-1:0]      i_nxt;
  logic [CNT_W-1:0]      j_nxt;
  logic                  i_last;
  logic                  j_last;
  logic                  it_init;
  logic                  it_adv;
  logic                  cap_hit;
  logic                  cnt_clr;
  logic                  cnt_inc;
  logic                  hit;

  pair_iterator #(
    .NUM_BODIES(NUM_BODIES),
    .CNT_W     (CNT_W)
  ) u_iter (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .init    (it_init),
    .advance (it_adv),
    .i       (i),
    .j       (j),
    .i_nxt_c (i_nxt),
    .j_nxt_c (j_nxt),
    .i_last_c(i_last),
    .j_last_c(j_last)
  );

  assign hit          = det_is_collision & mask_q[IDX_W'(i)] & mask_q[IDX_W'(j)];
  assign adv_state    = !j_last ? ST_RD_B : (!i_last ? ST_RD_A : ST_DONE);
  assign contact_data = contact_q;

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    it_init   = 1'b0;
    it_adv    = 1'b0;
    cap_hit   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          it_init   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_RD_A;
        end
      end
      ST_RD_A:  state_nxt = ST_CAP_A;
      ST_CAP_A: state_nxt = ST_CAP_B;
      ST_RD_B:  state_nxt = ST_CAP_B;
      ST_CAP_B: state_nxt = ST_EVAL;
      ST_EVAL: begin
        if (hit) begin
          cap_hit   = 1'b1;
          state_nxt = ST_EMIT;
        end else begin
          it_adv    = 1'b1;
          state_nxt = adv_state;
        end
      end
      ST_EMIT: begin
        if (contact_ready) begin
          cnt_inc   = 1'b1;
          it_adv    = 1'b1;
          state_nxt = adv_state;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status, stream-valid and RAM strobes registered from the upcoming state
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      body_rd_en    <= 1'b0;
      body_rd_addr  <= '0;
      contact_valid <= 1'b0;
    end else begin
      busy          <= (state_nxt != ST_IDLE);
      done          <= (state_nxt == ST_DONE);
      body_rd_en    <= (state_nxt inside {ST_RD_A, ST_CAP_A, ST_RD_B});
      contact_valid <= (state_nxt == ST_EMIT);
      if (state_nxt == ST_RD_A) begin
        body_rd_addr <= IDX_W'(i_nxt);
      end else if (state_nxt == ST_CAP_A || state_nxt == ST_RD_B) begin
        body_rd_addr <= IDX_W'(j_nxt);
      end
    end
  end

  // Body records, mask snapshot, captured contact and pass contact counter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      obb1_o        <= '0;
      obb2_o        <= '0;
      mask_q        <= '0;
      contact_q     <= '0;
      contact_idx_a <= '0;
      contact_idx_b <= '0;
      contact_count <= '0;
    end else begin
      if (state == ST_CAP_A) begin
        obb1_o <= body_rd_data;
      end
      if (state == ST_CAP_B) begin
        obb2_o <= body_rd_data;
      end
      if (it_init) begin
        mask_q <= active_mask;
      end
      if (cap_hit) begin
        contact_q     <= contact_t'(det_contact);
        contact_idx_a <= IDX_W'(i);
        contact_idx_b <= IDX_W'(j);
      end
      if (cnt_clr) begin
        contact_count <= '0;
      end else if (cnt_inc) begin
        contact_count <= contact_count + 16'd1;
      end
    end
  end

endmodule
